cache_bus_controller: RTL and testbench
=======================================

Name: cache_bus_controller

Overview:
- Requester-side bus controller for the cache units (IC/DC); the initiator counterpart of the memory bus controller.
- Accepts one 16-byte line request from the cache work unit.
- Arbitrates for the shared bus via BR/BG and issues the control phase (A, SIZE, RW, DEST).
- For writes, streams four 32-bit beats as master. For reads, waits as slave for memory's return transfer, acknowledges it, gathers four beats into a 128-bit line and hands it back.

Parameters:
- TIMEOUT_CYCLES, 32, cycles to wait for ACK_IN in the control phase (used only with the optional feature).
- LINE_BYTES, 16, bytes per transfer; the SIZE value driven on the bus; 4 beats of 4 bytes.

Ports:
- BUS_CLK  in  1  bus clock; all state updates on rising edge.
- RST  in  1  synchronous active-high reset.
- D  inout  32  bus data; driven only during own write beats, else Z.
- A  inout  16  bus address; driven only in MSTR, else Z.
- SIZE  inout  12  bus size; driven 12'h010 only in MSTR, else Z.
- RW  inout  1  bus direction (1 = write, 0 = read); driven only in MSTR, else Z.
- BR  out  1  bus request to arbiter.
- BG  in  1  bus grant.
- ACK_OUT  out  1  acknowledge to the memory master on a return transfer.
- ACK_IN  in  1  acknowledge from the addressed slave.
- DEST_OUT  out  1  selects memory as slave; high only in MSTR.
- DEST_IN  in  1  this unit addressed by the current bus master.
- REQ_VALID  in  1  work-unit request.
- REQ_RW  in  1  1 = line write, 0 = line read.
- REQ_ADDR  in  16  line address (bits [3:0] driven as given).
- REQ_WDATA  in  128  write line.
- REQ_READY  out  1  high only in IDLE.
- RESP_VALID  out  1  one-cycle completion pulse.
- RESP_RDATA  out  128  read line; held until the next read completes.
- RESP_ERR  out  1  timeout flag; valid with RESP_VALID; constant 0 without the optional feature.

Behaviour:
- Reset (synchronous, RST=1 at an edge):
  - State IDLE; BR=0, ACK_OUT=0, DEST_OUT=0, RESP_VALID=0, RESP_ERR=0, REQ_READY=1.
  - RESP_RDATA=0; beat counter=0; all inout drivers Z.
  - Reset mid-transaction aborts with no RESP_VALID.
- Accept: in IDLE, REQ_VALID=1 latches RW, ADDR and WDATA and moves to ST_BR. REQ_WDATA/REQ_ADDR changes after acceptance have no effect.
- ST_BR: BR=1. When BG=1 is sampled, go to MSTR.
- MSTR:
  - BR=1, DEST_OUT=1; drive A=addr, SIZE=12'h010, RW=latched RW.
  - When ACK_IN=1 is sampled: write goes to ST_WR with beat=0; read releases BR and goes to WAIT_RD.
  - Controls go Z on the cycle after the ACK.
  - BG dropping after MSTR is entered is ignored; the bus is held until done.
- ST_WR:
  - BR=1; drive D = WDATA[32k+31:32k] for beat k = 0..3 on consecutive cycles.
  - After beat 3: BR=0, D=Z, RESP_VALID=1 for one cycle, return to IDLE.
  - Write latency: ACK_IN sampled at cycle t, beats on t+1..t+4, RESP_VALID at t+5.
- WAIT_RD:
  - BR=0. When DEST_IN=1 and RW=1 are sampled at cycle t, go to ST_RD and assert ACK_OUT=1 for cycle t+1 only.
  - Capture D into line bits [32k+31:32k] at cycles t+2..t+5, k = 0..3.
  - RESP_RDATA updates and RESP_VALID=1 at t+6; return to IDLE.
- DEST_IN in any state other than WAIT_RD: ignored, no ACK_OUT.
- DEST_IN with RW=0 in WAIT_RD: ignored.
- Single outstanding request; REQ_VALID outside IDLE is ignored (not queued).
- Beat counter: 2 bits, wraps 3→0; completion is decoded at count 3.

Optional Feature:
- Macro: CACHE_BUS_TIMEOUT_EN.
- Enabled:
  - A counter clears on MSTR entry and increments each MSTR cycle without ACK_IN.
  - At TIMEOUT_CYCLES: BR=0, controls Z, RESP_VALID=1 with RESP_ERR=1, return to IDLE.
  - The same counter runs in WAIT_RD and produces the same error exit if DEST_IN never arrives.
- Disabled: waits indefinitely; RESP_ERR tied to 0.

Test Plan:
- Write: REQ_RW=1, ADDR=16'h0120, WDATA=128'h4444…_3333…_2222…_1111…; BG after 2 cycles; ACK_IN 1 cycle after MSTR -> bus shows A=0120, SIZE=010, RW=1, DEST_OUT=1; D beats 11111111, 22222222, 33333333, 44444444; RESP_VALID at t+5; BR low after.
- Read: REQ_RW=0, ADDR=16'h0040; ACK_IN; after 5 idle cycles, DEST_IN=1 with RW=1, then beats AAAA0000..AAAA0003 from t+2 -> ACK_OUT only at t+1; RESP_RDATA=128'hAAAA0003_AAAA0002_AAAA0001_AAAA0000 with RESP_VALID at t+6.
- Stray DEST_IN=1 in IDLE and during ST_WR -> ACK_OUT stays 0; write data and RESP unaffected.
- RST=1 mid-ST_WR beat 2 -> next cycle BR=0, D/A/SIZE/RW all Z, no RESP_VALID; a new request then completes normally.
- Arbitration delay: BG held 0 for 20 cycles -> BR stays 1, A stays Z until BG; REQ_VALID pulses meanwhile are ignored.
- With CACHE_BUS_TIMEOUT_EN and TIMEOUT_CYCLES=32, ACK_IN never asserted -> after 32 MSTR cycles: RESP_VALID=1, RESP_ERR=1, BR=0, REQ_READY=1.

Source files
------------

// File: rtl/cache_bus_controller.sv
// cache_bus_controller
//
// Requester-side bus controller for a cache unit. It accepts one 16-byte line
// request, arbitrates for the shared bus with BR/BG, and drives the control
// phase (A, SIZE, RW, DEST_OUT). A write then streams four 32-bit beats as bus
// master. A read releases the bus and waits as a slave. When memory calls back
// with DEST_IN=1 and RW=1, the controller acknowledges the call, collects four
// beats and returns the assembled line.
//
// Optional feature: define CACHE_BUS_TIMEOUT_EN to enable the timeout. In
// MSTR (waiting for ACK_IN) and in WAIT_RD (waiting for DEST_IN), the
// controller gives up after TIMEOUT_CYCLES cycles and completes with RESP_ERR=1.
// When the macro is undefined it waits forever and RESP_ERR stays at 0.
//
// Ports:
//   BUS_CLK     bus clock; all state changes on the rising edge
//   RST         synchronous active-high reset
//   D           bus data; driven only during this unit's write beats
//   A           bus address; driven only in MSTR
//   SIZE        bus size; drives LINE_BYTES only in MSTR
//   RW          bus direction (1 = write); driven only in MSTR
//   BR / BG     bus request / bus grant
//   ACK_OUT     acknowledge to memory on its return transfer
//   ACK_IN      acknowledge from the addressed slave
//   DEST_OUT    selects memory as the slave; high only in MSTR
//   DEST_IN     this unit is addressed by the current bus master
//   REQ_*       work-unit request (valid, rw, line address, write line)
//   REQ_READY   high only in IDLE
//   RESP_VALID  one-cycle completion pulse
//   RESP_RDATA  last read line; held until the next read completes
//   RESP_ERR    timeout flag; qualified by RESP_VALID

module cache_bus_controller #(
    parameter int unsigned TIMEOUT_CYCLES = 32,
    parameter int unsigned LINE_BYTES     = 16
) (
    input  logic         BUS_CLK,
    input  logic         RST,
    inout  wire  [31:0]  D,
    inout  wire  [15:0]  A,
    inout  wire  [11:0]  SIZE,
    inout  wire          RW,
    output logic         BR,
    input  logic         BG,
    output logic         ACK_OUT,
    input  logic         ACK_IN,
    output logic         DEST_OUT,
    input  logic         DEST_IN,
    input  logic         REQ_VALID,
    input  logic         REQ_RW,
    input  logic [15:0]  REQ_ADDR,
    input  logic [127:0] REQ_WDATA,
    output logic         REQ_READY,
    output logic         RESP_VALID,
    output logic [127:0] RESP_RDATA,
    output logic         RESP_ERR
);

    // The beat sequencing is fixed at four 32-bit beats per line.
    if (LINE_BYTES != 16 || TIMEOUT_CYCLES == 0) begin : g_bad_cfg
        $error("cache_bus_controller: LINE_BYTES must be 16 and TIMEOUT_CYCLES nonzero");
    end

    typedef enum logic [2:0] {
        StIdle,
        StBr,
        StMstr,
        StWr,
        StWaitRd,
        StRd
    } state_e;

    state_e         state_q;
    logic           rw_q;
    logic [15:0]    addr_q;
    logic [127:0]   wdata_q;
    logic [1:0]     beat_q;
    logic [95:0]    line_q;        // beats 0..2; beat 3 goes straight to RESP_RDATA
    logic [127:0]   resp_rdata_q;
    logic           br_q;
    logic           dest_q;
    logic           ack_q;
    logic           resp_valid_q;
    logic           ready_q;
    logic           drv_ctl_q;     // drive A/SIZE/RW
    logic           drv_d_q;       // drive D with the current write beat
    logic [31:0]    wr_beat;

`ifdef CACHE_BUS_TIMEOUT_EN
    localparam int unsigned ToW = $clog2(TIMEOUT_CYCLES + 1);
    logic [ToW-1:0] to_cnt_q;
    logic           resp_err_q;
    logic           to_expired;

    assign to_expired = (to_cnt_q == ToW'(TIMEOUT_CYCLES - 1));
    assign RESP_ERR   = resp_err_q;
`else
    assign RESP_ERR   = 1'b0;
`endif

    assign wr_beat = wdata_q[{beat_q, 5'd0} +: 32];

    assign D    = drv_d_q   ? wr_beat            : 'z;
    assign A    = drv_ctl_q ? addr_q             : 'z;
    assign SIZE = drv_ctl_q ? 12'(LINE_BYTES)    : 'z;
    assign RW   = drv_ctl_q ? rw_q               : 1'bz;

    assign BR         = br_q;
    assign DEST_OUT   = dest_q;
    assign ACK_OUT    = ack_q;
    assign REQ_READY  = ready_q;
    assign RESP_VALID = resp_valid_q;
    assign RESP_RDATA = resp_rdata_q;

    always_ff @(posedge BUS_CLK) begin
        if (RST) begin
            state_q      <= StIdle;
            rw_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            beat_q       <= 2'd0;
            line_q       <= '0;
            resp_rdata_q <= '0;
            br_q         <= 1'b0;
            dest_q       <= 1'b0;
            ack_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            ready_q      <= 1'b1;
            drv_ctl_q    <= 1'b0;
            drv_d_q      <= 1'b0;
`ifdef CACHE_BUS_TIMEOUT_EN
            to_cnt_q     <= '0;
            resp_err_q   <= 1'b0;
`endif
        end else begin
            // Pulses default low and are raised only on the cycle they apply.
            resp_valid_q <= 1'b0;
            ack_q        <= 1'b0;
`ifdef CACHE_BUS_TIMEOUT_EN
            resp_err_q   <= 1'b0;
`endif
            case (state_q)
                StIdle: begin
                    if (REQ_VALID) begin
                        rw_q    <= REQ_RW;
                        addr_q  <= REQ_ADDR;
                        wdata_q <= REQ_WDATA;
                        br_q    <= 1'b1;
                        ready_q <= 1'b0;
                        state_q <= StBr;
                    end
                end

                StBr: begin
                    if (BG) begin
                        dest_q    <= 1'b1;
                        drv_ctl_q <= 1'b1;
                        state_q   <= StMstr;
`ifdef CACHE_BUS_TIMEOUT_EN
                        to_cnt_q  <= '0;
`endif
                    end
                end

                // BG is no longer looked at: the bus is held until the transfer ends.
                StMstr: begin
                    if (ACK_IN) begin
                        dest_q    <= 1'b0;
                        drv_ctl_q <= 1'b0;
                        if (rw_q) begin
                            beat_q  <= 2'd0;
                            drv_d_q <= 1'b1;
                            state_q <= StWr;
                        end else begin
                            br_q    <= 1'b0;
                            state_q <= StWaitRd;
`ifdef CACHE_BUS_TIMEOUT_EN
                            to_cnt_q <= '0;
`endif
                        end
                    end
`ifdef CACHE_BUS_TIMEOUT_EN
                    else if (to_expired) begin
                        dest_q       <= 1'b0;
                        drv_ctl_q    <= 1'b0;
                        br_q         <= 1'b0;
                        ready_q      <= 1'b1;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b1;
                        state_q      <= StIdle;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
`endif
                end

                StWr: begin
                    beat_q <= beat_q + 2'd1;
                    if (beat_q == 2'd3) begin
                        br_q         <= 1'b0;
                        drv_d_q      <= 1'b0;
                        ready_q      <= 1'b1;
                        resp_valid_q <= 1'b1;
                        state_q      <= StIdle;
                    end
                end

                // Only a memory write transfer addressed to us counts as the read return.
                StWaitRd: begin
                    if (DEST_IN && RW) begin
                        ack_q   <= 1'b1;
                        beat_q  <= 2'd0;
                        state_q <= StRd;
                    end
`ifdef CACHE_BUS_TIMEOUT_EN
                    else if (to_expired) begin
                        ready_q      <= 1'b1;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b1;
                        state_q      <= StIdle;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
`endif
                end

                // First cycle is the ACK_OUT cycle; data beats follow on the next four.
                StRd: begin
                    if (!ack_q) begin
                        beat_q <= beat_q + 2'd1;
                        case (beat_q)
                            2'd0:    line_q[31:0]  <= D;
                            2'd1:    line_q[63:32] <= D;
                            2'd2:    line_q[95:64] <= D;
                            default: begin
                                resp_rdata_q <= {D, line_q};
                                ready_q      <= 1'b1;
                                resp_valid_q <= 1'b1;
                                state_q      <= StIdle;
                            end
                        endcase
                    end
                end

                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_bus_controller.sv
// Testbench for cache_bus_controller. Each task plays the bus partners (the
// arbiter and memory) for one scenario and checks the controller against
// expectations that follow from the line-transfer rules. Pull resistors on the
// shared bus let an undriven line read as all-ones (RW reads as 0).
module tb_cache_bus_controller;

    localparam int unsigned TimeoutCycles = 32;

    logic         BUS_CLK = 1'b0;
    logic         RST = 1'b1;
    logic         BG = 1'b0;
    logic         ACK_IN = 1'b0;
    logic         DEST_IN = 1'b0;
    logic         REQ_VALID = 1'b0;
    logic         REQ_RW = 1'b0;
    logic [15:0]  REQ_ADDR = '0;
    logic [127:0] REQ_WDATA = '0;
    logic         BR, ACK_OUT, DEST_OUT, REQ_READY, RESP_VALID, RESP_ERR;
    logic [127:0] RESP_RDATA;

    wire  [31:0]  D;
    wire  [15:0]  A;
    wire  [11:0]  SIZE;
    wire          RW;

    logic         tb_d_en = 1'b0;
    logic [31:0]  tb_d = '0;
    logic         tb_rw_en = 1'b0;

    assign D  = tb_d_en  ? tb_d : 'z;
    assign RW = tb_rw_en ? 1'b1 : 1'bz;

    pullup   (D);
    pullup   (A);
    pullup   (SIZE);
    pulldown (RW);

    // {BR, REQ_READY, DEST_OUT, ACK_OUT, RESP_VALID, RESP_ERR}
    wire [5:0] ctl = {BR, REQ_READY, DEST_OUT, ACK_OUT, RESP_VALID, RESP_ERR};

    int tests_run = 0;
    int tests_failed = 0;

    always #5 BUS_CLK = ~BUS_CLK;

    cache_bus_controller #(
        .TIMEOUT_CYCLES (TimeoutCycles),
        .LINE_BYTES     (16)
    ) u_dut (
        .BUS_CLK    (BUS_CLK),
        .RST        (RST),
        .D          (D),
        .A          (A),
        .SIZE       (SIZE),
        .RW         (RW),
        .BR         (BR),
        .BG         (BG),
        .ACK_OUT    (ACK_OUT),
        .ACK_IN     (ACK_IN),
        .DEST_OUT   (DEST_OUT),
        .DEST_IN    (DEST_IN),
        .REQ_VALID  (REQ_VALID),
        .REQ_RW     (REQ_RW),
        .REQ_ADDR   (REQ_ADDR),
        .REQ_WDATA  (REQ_WDATA),
        .REQ_READY  (REQ_READY),
        .RESP_VALID (RESP_VALID),
        .RESP_RDATA (RESP_RDATA),
        .RESP_ERR   (RESP_ERR)
    );

    // Advance one cycle; outputs are then stable and inputs may change.
    task automatic tick();
        @(posedge BUS_CLK);
        #1;
    endtask

    // Full line write: arbitration wait of bg_delay extra cycles, ACK one cycle
    // into MSTR, then four beats and a completion pulse.
    task automatic do_write(input logic [15:0] addr, input logic [127:0] wdata,
                            input int bg_delay, input bit stray, input bit pulse);
        logic [31:0] exp_beat;
        REQ_VALID = 1'b1; REQ_RW = 1'b1; REQ_ADDR = addr; REQ_WDATA = wdata;
        DEST_IN = stray; tb_rw_en = stray;
        tick();
        REQ_VALID = 1'b0; REQ_RW = 1'b0; REQ_ADDR = ~addr; REQ_WDATA = ~wdata;
        for (int i = 0; i <= bg_delay; i++) begin
            if (pulse) REQ_VALID = i[0];
            tests_run++;
            if ({ctl, A} !== {6'b100000, 16'hFFFF}) begin
                tests_failed++;
                $display("FAIL wr_arb_wait: ctl/A got %b/%h want 100000/ffff", ctl, A);
            end
            if (i == bg_delay) begin
                REQ_VALID = 1'b0;
                BG = 1'b1;
            end
            tick();
        end
        BG = 1'b0;
        tests_run++;
        if ({ctl, A, SIZE, RW} !== {6'b101000, addr, 12'h010, 1'b1}) begin
            tests_failed++;
            $display("FAIL wr_ctrl_phase: ctl/A/SIZE/RW got %b/%h/%h/%b want 101000/%h/010/1",
                     ctl, A, SIZE, RW, addr);
        end
        ACK_IN = 1'b1;
        tick();
        ACK_IN = 1'b0;
        for (int k = 0; k < 4; k++) begin
            exp_beat = 32'(wdata >> (32 * k));
            tests_run++;
            if (D !== exp_beat) begin
                tests_failed++;
                $display("FAIL wr_beat%0d: D got %h want %h", k, D, exp_beat);
            end
            tests_run++;
            if ({ctl, A, SIZE} !== {6'b100000, 16'hFFFF, 12'hFFF}) begin
                tests_failed++;
                $display("FAIL wr_beat_ctl%0d: ctl/A/SIZE got %b/%h/%h want 100000/ffff/fff",
                         k, ctl, A, SIZE);
            end
            tick();
        end
        tests_run++;
        if ({ctl, D} !== {6'b010010, 32'hFFFF_FFFF}) begin
            tests_failed++;
            $display("FAIL wr_resp: ctl/D got %b/%h want 010010/ffffffff", ctl, D);
        end
        DEST_IN = 1'b0; tb_rw_en = 1'b0;
        tick();
        tests_run++;
        if (ctl !== 6'b010000) begin
            tests_failed++;
            $display("FAIL wr_after: ctl got %b want 010000", ctl);
        end
    endtask

    // Full line read: memory calls back after gap idle cycles and returns line.
    task automatic do_read(input logic [15:0] addr, input int bg_delay, input int gap,
                           input logic [127:0] line, input bit stray_rw0);
        REQ_VALID = 1'b1; REQ_RW = 1'b0; REQ_ADDR = addr; REQ_WDATA = ~line;
        tick();
        REQ_VALID = 1'b0; REQ_ADDR = ~addr;
        for (int i = 0; i <= bg_delay; i++) begin
            tests_run++;
            if ({ctl, A} !== {6'b100000, 16'hFFFF}) begin
                tests_failed++;
                $display("FAIL rd_arb_wait: ctl/A got %b/%h want 100000/ffff", ctl, A);
            end
            if (i == bg_delay) BG = 1'b1;
            tick();
        end
        BG = 1'b0;
        tests_run++;
        if ({ctl, A, SIZE, RW} !== {6'b101000, addr, 12'h010, 1'b0}) begin
            tests_failed++;
            $display("FAIL rd_ctrl_phase: ctl/A/SIZE/RW got %b/%h/%h/%b want 101000/%h/010/0",
                     ctl, A, SIZE, RW, addr);
        end
        ACK_IN = 1'b1;
        tick();
        ACK_IN = 1'b0;
        for (int i = 0; i < gap; i++) begin
            DEST_IN = stray_rw0;
            tests_run++;
            if ({ctl, A, SIZE, D} !== {6'b000000, 16'hFFFF, 12'hFFF, 32'hFFFF_FFFF}) begin
                tests_failed++;
                $display("FAIL rd_wait: ctl/A/SIZE/D got %b/%h/%h/%h want 000000/ffff/fff/ffffffff",
                         ctl, A, SIZE, D);
            end
            tick();
        end
        DEST_IN = 1'b1; tb_rw_en = 1'b1;
        tests_run++;
        if (ctl !== 6'b000000) begin
            tests_failed++;
            $display("FAIL rd_pre_call: ctl got %b want 000000", ctl);
        end
        tick();
        DEST_IN = 1'b0;
        tests_run++;
        if (ctl !== 6'b000100) begin
            tests_failed++;
            $display("FAIL rd_ack: ctl got %b want 000100", ctl);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            tests_run++;
            if (ctl !== 6'b000000) begin
                tests_failed++;
                $display("FAIL rd_beat_ctl%0d: ctl got %b want 000000", k, ctl);
            end
            tb_d = line[32 * k +: 32];
            tb_d_en = 1'b1;
        end
        tick();
        tb_d_en = 1'b0; tb_rw_en = 1'b0;
        tests_run++;
        if ({ctl, RESP_RDATA} !== {6'b010010, line}) begin
            tests_failed++;
            $display("FAIL rd_resp: ctl/RDATA got %b/%h want 010010/%h", ctl, RESP_RDATA, line);
        end
        tick();
        tests_run++;
        if ({ctl, RESP_RDATA} !== {6'b010000, line}) begin
            tests_failed++;
            $display("FAIL rd_hold: ctl/RDATA got %b/%h want 010000/%h", ctl, RESP_RDATA, line);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        tick();
        tick();
        tests_run++;
        if ({ctl, RESP_RDATA} !== {6'b010000, 128'h0}) begin
            tests_failed++;
            $display("FAIL reset_outputs: ctl/RDATA got %b/%h want 010000/0", ctl, RESP_RDATA);
        end
        tests_run++;
        if ({A, SIZE, D, RW} !== {16'hFFFF, 12'hFFF, 32'hFFFF_FFFF, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_bus_z: A/SIZE/D/RW got %h/%h/%h/%b want released",
                     A, SIZE, D, RW);
        end
        RST = 1'b0;
        tick();
        tests_run++;
        if (ctl !== 6'b010000) begin
            tests_failed++;
            $display("FAIL reset_idle: ctl got %b want 010000", ctl);
        end
    endtask

    task automatic test_write();
        do_write(16'h0120, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, 2, 1'b0,
                 1'b0);
    endtask

    task automatic test_read();
        do_read(16'h0040, 1, 5, {32'hAAAA0003, 32'hAAAA0002, 32'hAAAA0001, 32'hAAAA0000}, 1'b0);
    endtask

    task automatic test_stray_dest();
        DEST_IN = 1'b1; tb_rw_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            tests_run++;
            if (ctl !== 6'b010000) begin
                tests_failed++;
                $display("FAIL stray_idle: ctl got %b want 010000", ctl);
            end
        end
        DEST_IN = 1'b0; tb_rw_en = 1'b0;
        do_write(16'h0340, {$urandom, $urandom, $urandom, $urandom}, 1, 1'b1, 1'b0);
        // A read with a DEST_IN that carries RW=0 while waiting for the return.
        do_read(16'h0350, 0, 4, {$urandom, $urandom, $urandom, $urandom}, 1'b1);
    endtask

    task automatic test_reset_mid_write();
        logic [127:0] wdata;
        wdata = {$urandom, $urandom, $urandom, $urandom};
        REQ_VALID = 1'b1; REQ_RW = 1'b1; REQ_ADDR = 16'h0200; REQ_WDATA = wdata;
        tick();
        REQ_VALID = 1'b0; BG = 1'b1;
        tick();
        BG = 1'b0; ACK_IN = 1'b1;
        tick();
        ACK_IN = 1'b0;
        tick();
        tick();
        tests_run++;
        if (D !== wdata[95:64]) begin
            tests_failed++;
            $display("FAIL rstwr_beat2: D got %h want %h", D, wdata[95:64]);
        end
        RST = 1'b1;
        tick();
        RST = 1'b0;
        tests_run++;
        if ({ctl, A, SIZE, RW, D} !== {6'b010000, 16'hFFFF, 12'hFFF, 1'b0, 32'hFFFF_FFFF}) begin
            tests_failed++;
            $display("FAIL rstwr_abort: ctl/A/SIZE/RW/D got %b/%h/%h/%b/%h want 010000/released",
                     ctl, A, SIZE, RW, D);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            tests_run++;
            if (ctl !== 6'b010000) begin
                tests_failed++;
                $display("FAIL rstwr_no_resp: ctl got %b want 010000", ctl);
            end
        end
        do_write(16'h0210, {$urandom, $urandom, $urandom, $urandom}, 0, 1'b0, 1'b0);
    endtask

    task automatic test_arb_delay();
        do_write(16'h0560, {$urandom, $urandom, $urandom, $urandom}, 20, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        logic [127:0] data;
        logic [15:0]  addr;
        for (int n = 0; n < 12; n++) begin
            data = {$urandom, $urandom, $urandom, $urandom};
            addr = 16'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                do_write(addr, data, int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 1)));
            end else begin
                do_read(addr, int'($urandom_range(0, 4)), int'($urandom_range(0, 6)), data,
                        1'($urandom_range(0, 1)));
            end
        end
    endtask

`ifdef CACHE_BUS_TIMEOUT_EN
    task automatic test_timeout();
        REQ_VALID = 1'b1; REQ_RW = 1'b1; REQ_ADDR = 16'h0700;
        tick();
        REQ_VALID = 1'b0; BG = 1'b1;
        tick();
        BG = 1'b0;
        for (int i = 0; i < int'(TimeoutCycles); i++) begin
            tests_run++;
            if (ctl !== 6'b101000) begin
                tests_failed++;
                $display("FAIL to_mstr_wait: ctl got %b want 101000", ctl);
            end
            tick();
        end
        tests_run++;
        if ({ctl, A} !== {6'b010011, 16'hFFFF}) begin
            tests_failed++;
            $display("FAIL to_mstr_exit: ctl/A got %b/%h want 010011/ffff", ctl, A);
        end
        tick();
        REQ_VALID = 1'b1; REQ_RW = 1'b0; REQ_ADDR = 16'h0710;
        tick();
        REQ_VALID = 1'b0; BG = 1'b1;
        tick();
        BG = 1'b0; ACK_IN = 1'b1;
        tick();
        ACK_IN = 1'b0;
        for (int i = 0; i < int'(TimeoutCycles); i++) begin
            tests_run++;
            if (ctl !== 6'b000000) begin
                tests_failed++;
                $display("FAIL to_rd_wait: ctl got %b want 000000", ctl);
            end
            tick();
        end
        tests_run++;
        if (ctl !== 6'b010011) begin
            tests_failed++;
            $display("FAIL to_rd_exit: ctl got %b want 010011", ctl);
        end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_read();
        test_stray_dest();
        test_reset_mid_write();
        test_arb_delay();
        test_random();
`ifdef CACHE_BUS_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
